sa_feeder: RTL and testbench

Input-staging and skew stage sitting directly upstream of the 8×8 systolic array. Accepts one A matrix and one B matrix over a valid/ready load port, one k-slice per beat. Then drives the array's west (A) and north (B) edges with the diagonally skewed operand wavefront. Clears the array's accumulators before each run and signals `done` once every PE holds its final C[i][j].

---
 rtl/sa_pkg.sv | 17 +
 rtl/sa_feeder_if.sv | 26 ++
 rtl/sa_skew_mux.sv | 24 ++
 rtl/sa_feeder.sv | 145 ++++++++++++++
 tb/tb_sa_feeder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array input feeder: default geometry and FSM states.
package sa_pkg;

  parameter int unsigned SA_N     = 8;
  parameter int unsigned SA_WIDTH = 8;

  localparam int unsigned FEED_CYC = 3 * SA_N - 2;

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StFeed,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sa_feeder_if.sv
// Load port of the feeder: one valid/ready beat carries A column k and B row k.
interface sa_feeder_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_a;
  logic [N*WIDTH-1:0]   in_b;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output in_ready
  );

endinterface

// File: rtl/sa_skew_mux.sv
// Diagonal wavefront selector: lane i carries mat[i][t-i] inside the window, zero elsewhere.
module sa_skew_mux #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TW    = 5
) (
  input  logic [N-1:0][N-1:0][WIDTH-1:0] mat_i,
  input  logic [TW-1:0]                  t_i,
  output logic [N*WIDTH-1:0]             lanes_o
);

  // Compare against constant i+k rather than indexing by t-i, so no wide index arithmetic.
  always_comb begin
    lanes_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_i) == i + k) begin
          lanes_o[i*WIDTH +: WIDTH] = mat_i[i][k];
        end
      end
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// Loads A/B over a valid/ready port, then clears the array and drives the skewed wavefront.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int unsigned N         = SA_N,
  parameter int unsigned WIDTH     = SA_WIDTH,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sa_feeder_if.slave         load,
  output logic [N*WIDTH-1:0] sa_a,
  output logic [N*WIDTH-1:0] sa_b,
  output logic               sa_rst,
  output logic               busy,
  output logic               done
);

  localparam int unsigned FeedCyc = 3 * N - 2;
  localparam int unsigned CntW    = $clog2(FeedCyc + DRAIN_CYC);

  // Both buffers are stored lane-major: a_buf[i][k] = A[i][k], b_buf[j][k] = B[k][j].
  logic [N-1:0][N-1:0][WIDTH-1:0] a_buf;
  logic [N-1:0][N-1:0][WIDTH-1:0] b_buf;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [CntW-1:0]    t_next;
  logic               in_ready_q;
  logic               accept;
  logic [N*WIDTH-1:0] skew_a;
  logic [N*WIDTH-1:0] skew_b;

  assign load.in_ready = in_ready_q;
  assign accept        = load.in_valid && in_ready_q;

  // Outputs are registered, so the muxes look at the slot about to be presented.
  assign t_next = (state_q == StClear) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (accept && state_q == StLoad) begin
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CntW'(k)) begin
          for (int i = 0; i < N; i++) begin
            a_buf[i][k] <= load.in_a[i*WIDTH +: WIDTH];
            b_buf[i][k] <= load.in_b[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  sa_skew_mux #(
    .N     (N),
    .WIDTH (WIDTH),
    .TW    (CntW)
  ) u_skew_a (
    .mat_i   (a_buf),
    .t_i     (t_next),
    .lanes_o (skew_a)
  );

  sa_skew_mux #(
    .N     (N),
    .WIDTH (WIDTH),
    .TW    (CntW)
  ) u_skew_b (
    .mat_i   (b_buf),
    .t_i     (t_next),
    .lanes_o (skew_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      sa_a       <= '0;
      sa_b       <= '0;
      sa_rst     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          in_ready_q <= 1'b1;
          sa_rst     <= 1'b0;
          if (accept) begin
            if (cnt_q == CntW'(N - 1)) begin
              state_q    <= StClear;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              busy       <= 1'b1;
              sa_rst     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StClear: begin
          state_q <= StFeed;
          cnt_q   <= '0;
          sa_rst  <= 1'b0;
          sa_a    <= skew_a;
          sa_b    <= skew_b;
        end
        StFeed: begin
          if (cnt_q == CntW'(FeedCyc - 1)) begin
            cnt_q <= '0;
            sa_a  <= '0;
            sa_b  <= '0;
            if (DRAIN_CYC == 0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            sa_a  <= skew_a;
            sa_b  <= skew_b;
          end
        end
        StDrain: begin
          if (cnt_q == CntW'(DRAIN_CYC - 1)) begin
            state_q <= StDone;
            cnt_q   <= '0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q    <= StLoad;
          cnt_q      <= '0;
          done       <= 1'b0;
          busy       <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Randomised bench for sa_feeder with a behavioural output-stationary array on its outputs.
module tb_sa_feeder;

  localparam int N = 8;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] sa_a;
  logic [N*W-1:0] sa_b;
  logic           sa_rst;
  logic           busy;
  logic           done;

  sa_feeder_if #(.N(N), .WIDTH(W)) lif ();

  sa_feeder #(
    .N         (N),
    .WIDTH     (W),
    .DRAIN_CYC (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lif.slave),
    .sa_a   (sa_a),
    .sa_b   (sa_b),
    .sa_rst (sa_rst),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int am [N][N];
  int bm [N][N];

  // Output-stationary PE grid fed by the DUT, so end results can be checked against A*B.
  int   acc [N][N];
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [W-1:0] ain, bin;
        ain = (j == 0) ? sa_a[i*W +: W] : pa[i][j-1];
        bin = (i == 0) ? sa_b[j*W +: W] : pb[i-1][j];
        if (sa_rst) begin
          acc[i][j] <= 0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_a(int t);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*W +: W] = am[i][t-i][W-1:0];
    return v;
  endfunction

  function automatic logic [63:0] exp_b(int t);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*W +: W] = bm[t-j][j][W-1:0];
    return v;
  endfunction

  task automatic set_mats(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        unique case (mode)
          1: begin am[i][j] = 16 * i + j; bm[i][j] = 16 * i + j; end
          2: begin am[i][j] = 1;          bm[i][j] = 1;          end
          3: begin am[i][j] = (i == j) ? 1 : 0; bm[i][j] = i + j; end
          default: begin
            am[i][j] = int'($urandom_range(255));
            bm[i][j] = int'($urandom_range(255));
          end
        endcase
      end
    end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      lif.in_a[i*W +: W] = am[i][k][W-1:0];
      lif.in_b[i*W +: W] = bm[k][i][W-1:0];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_status"}, 64'({lif.in_ready, busy, sa_rst, done}), 64'b0010);
    check({tag, "_sa_a"}, sa_a, '0);
    check({tag, "_sa_b"}, sa_b, '0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n        = 1'b0;
    lif.in_valid = 1'b0;
    #1 check_reset_vals("rst_async");
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1 check_reset_vals("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_release", 64'({lif.in_ready, busy, sa_rst, done}), 64'b1000);
  endtask

  // Loads beats (optionally gapped); returns once the final beat has been accepted.
  task automatic load_beats(input int nbeats, input bit gap);
    int k = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (k < nbeats && guard < 100) begin
      @(negedge clk);
      tog = ~tog;
      lif.in_valid = !(gap && !tog);
      drive_beat(k);
      @(posedge clk);
      guard++;
      if (lif.in_valid) k++;
      #1;
      if (k < N) check("load_status", 64'({lif.in_ready, busy, sa_rst, done}), 64'b1000);
    end
    if (k < nbeats) check("load_timeout", 64'(k), 64'(nbeats));
  endtask

  task automatic run_job(input int mode, input bit gap, input bit junk, input int abort_t);
    set_mats(mode);
    load_beats(N, gap);
    // m counts edges after the final accepting edge.
    for (int m = 0; m <= 26; m++) begin
      if (m > 0) begin
        @(negedge clk);
        lif.in_valid = junk;
        if (junk) begin
          lif.in_a = {$urandom, $urandom};
          lif.in_b = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
      end
      check("status", 64'({lif.in_ready, busy, sa_rst, done}),
            64'({m == 26, m <= 25, m == 0, m == 25}));
      check("sa_a", sa_a, (m >= 1 && m <= 22) ? exp_a(m - 1) : 64'h0);
      check("sa_b", sa_b, (m >= 1 && m <= 22) ? exp_b(m - 1) : 64'h0);
      if (mode == 1 && m == 8) begin
        check("pat_t7_a0", 64'(sa_a[7:0]), 64'h07);
        check("pat_t7_a7", 64'(sa_a[63:56]), 64'h70);
        check("pat_t7_b3", 64'(sa_b[31:24]), 64'h43);
      end
      if (mode == 1 && m == 15) begin
        check("pat_t14_a", sa_a, 64'h7700_0000_0000_0000);
        check("pat_t14_b", sa_b, 64'h7700_0000_0000_0000);
      end
      if (mode == 1 && m == 22) check("pat_t21_a", sa_a, 64'h0);
      if (m == 25) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            int c = 0;
            for (int k = 0; k < N; k++) c += am[i][k] * bm[k][j];
            check($sformatf("c_%0d_%0d", i, j), 64'(acc[i][j]), 64'(c));
          end
        end
      end
      if (abort_t >= 0 && m == abort_t + 1) begin
        do_reset(2);
        return;
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_a     = '0;
    lif.in_b     = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check_reset_vals("por");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("por_ready", 64'({lif.in_ready, busy, sa_rst, done}), 64'b1000);

    run_job(1, 1'b0, 1'b0, -1);
    run_job(2, 1'b0, 1'b0, -1);
    run_job(3, 1'b1, 1'b0, -1);
    run_job(0, 1'b1, 1'b0, -1);
    run_job(0, 1'b0, 1'b1, -1);
    run_job(0, 1'b0, 1'b0, 10);
    run_job(0, 1'b0, 1'b0, -1);
    set_mats(0);
    load_beats(3, 1'b0);
    do_reset(1);
    run_job(0, 1'b1, 1'b1, -1);
    run_job(0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
